l2_port_scheduler: RTL and testbench
====================================

// Module: l2_port_scheduler
// PURPOSE
//  Shares the single 256-bit L2 request port between the I-cache (read-only) and D-cache (read/write) miss paths.
//  Combines grant FSM, address/data muxing and response-return registering in one block.
//  Sits between the two L1 caches and l2_cache. One L2 transaction in flight at a time.
//  Bounds I-side starvation under a steady D-side miss stream.
// PARAMETERS
//  STARVE_LIMIT  4    consecutive D grants allowed while I is pending before I is forced (1..15)
//  LINE_W        256  cache line width in bits
// PORTS
//  clk             in   1       clock
//  rst             in   1       synchronous reset, active-high
//  i_pmem_read     in   1       I-cache line read request (level, held until i_pmem_resp)
//  i_pmem_address  in   32      I-cache line address
//  i_pmem_rdata    out  LINE_W  line returned to I-cache
//  i_pmem_resp     out  1       one-cycle completion pulse to I-cache
//  d_pmem_read     in   1       D-cache line read request
//  d_pmem_write    in   1       D-cache line writeback request
//  d_pmem_address  in   32      D-cache line address
//  d_pmem_wdata    in   LINE_W  D-cache writeback line
//  d_pmem_rdata    out  LINE_W  line returned to D-cache
//  d_pmem_resp     out  1       one-cycle completion pulse to D-cache
//  a_pmem_read     out  1       L2 read request
//  a_pmem_write    out  1       L2 write request
//  a_pmem_address  out  32      L2 address
//  a_pmem_wdata    out  LINE_W  L2 write line
//  a_pmem_rdata    in   LINE_W  L2 read line
//  a_pmem_resp     in   1       L2 completion
//  busy            out  1       FSM not in IDLE
// BEHAVIOUR
//  Reset values: every output is 0; FSM = IDLE; starve_cnt = 0; rr_last = D.
//  States: IDLE -> SERVE_I | SERVE_D -> RESP_I | RESP_D -> IDLE.
//  IDLE: evaluate requests; on a winner, latch address, op and (for D writes) wdata into holding registers.
//    Move to SERVE_x next cycle. No request: stay in IDLE.
//  SERVE_x: a_pmem_* driven from the holding registers only, never from live inputs.
//    a_pmem_read/a_pmem_write are asserted for every SERVE cycle up to and including the a_pmem_resp cycle.
//    On a_pmem_resp: latch a_pmem_rdata into the x-side rdata register; go to RESP_x.
//  RESP_x: x_pmem_resp = 1 for exactly one cycle, with x_pmem_rdata valid; go to IDLE. No L2 request is driven.
//  Latency: request first seen in IDLE at cycle n -> a_pmem_* at n+1.
//    a_pmem_resp at cycle m -> x_pmem_resp at m+1 -> IDLE at m+2.
//    Back-to-back transactions are 1 idle cycle apart.
//  x_pmem_rdata holds its last latched value outside RESP_x. The other side's rdata and resp are never disturbed.
//  Arbitration (macro undefined): fixed priority, D over I.
//    Exception: if i_pmem_read is pending and starve_cnt == STARVE_LIMIT, I wins.
//    starve_cnt increments on each D grant while i_pmem_read = 1, clears on any I grant, and saturates at STARVE_LIMIT.
//  d_pmem_read and d_pmem_write both high is illegal; write takes precedence and the read is ignored.
//  Request dropped after grant: the transaction still completes and resp still pulses.
//    Memory side is never aborted.
//  Request dropped before IDLE samples it: no grant.
//  rst mid-transaction: FSM returns to IDLE and all outputs go to 0 next cycle.
//    rst is system-wide, so L2 is reset in the same cycle.
// CONFIGURATION
//  ARB_ROUND_ROBIN_EN defined:
//    simultaneous I and D requests in IDLE go to the side not in rr_last; rr_last updates on every grant.
//    Uncontended requests are granted immediately. starve_cnt and STARVE_LIMIT are unused; starve_cnt is tied to 0.
//  ARB_ROUND_ROBIN_EN undefined: fixed priority plus starvation limit, as above.
// TESTING
//  I read only, addr 0x0000_0040, L2 resp after 3 cycles with line A
//    -> a_pmem_read for 3 cycles, addr 0x40; i_pmem_resp 1 cycle later with rdata = A; d_pmem_resp stays 0.
//  D write addr 0x0000_1000, wdata B; d_pmem_wdata changed to C mid-SERVE
//    -> a_pmem_write with wdata B throughout; d_pmem_resp pulses once.
//  I and D read both requested in the same IDLE cycle, macro undefined
//    -> D served first, I second; exactly one a_pmem_* active at any time; 1 idle cycle between them.
//  I held high while D requests continuously, STARVE_LIMIT = 4, macro undefined
//    -> 4 D grants, then I granted; counter clears; D resumes.
//  Same continuous contention with ARB_ROUND_ROBIN_EN defined -> grants alternate I, D, I, D, starting with I.
//  rst asserted in SERVE_D with L2 not yet responded
//    -> next cycle: busy = 0, a_pmem_* = 0, no resp pulse; a fresh I request is then served normally.

Source files
------------

// File: rtl/l2_port_scheduler.sv
// rtl/l2_port_scheduler.sv - shares one L2 request port between I-cache and D-cache miss paths.
// Optional ARB_ROUND_ROBIN_EN selects round-robin arbitration instead of D-priority with starvation limit.
module l2_port_scheduler #(
    parameter int STARVE_LIMIT = 4,
    parameter int LINE_W       = 256
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_pmem_read,
    input  logic [31:0]       i_pmem_address,
    output logic [LINE_W-1:0] i_pmem_rdata,
    output logic              i_pmem_resp,
    input  logic              d_pmem_read,
    input  logic              d_pmem_write,
    input  logic [31:0]       d_pmem_address,
    input  logic [LINE_W-1:0] d_pmem_wdata,
    output logic [LINE_W-1:0] d_pmem_rdata,
    output logic              d_pmem_resp,
    output logic              a_pmem_read,
    output logic              a_pmem_write,
    output logic [31:0]       a_pmem_address,
    output logic [LINE_W-1:0] a_pmem_wdata,
    input  logic [LINE_W-1:0] a_pmem_rdata,
    input  logic              a_pmem_resp,
    output logic              busy
);

    typedef enum logic [2:0] {IDLE, SERVE_I, SERVE_D, RESP_I, RESP_D} state_t;

    state_t            state, state_next;
    logic              d_req;
    logic              grant_i, grant_d;
    logic [31:0]       hold_addr;
    logic              hold_write;
    logic [LINE_W-1:0] hold_wdata;
    logic [LINE_W-1:0] i_rdata_q, d_rdata_q;

    assign d_req = d_pmem_read | d_pmem_write;

`ifdef ARB_ROUND_ROBIN_EN
    // rr_last = 1 means D was granted most recently
    logic rr_last;

    always_comb begin
        grant_i = i_pmem_read && (!d_req || rr_last);
        grant_d = d_req && !grant_i;
    end

    always_ff @(posedge clk) begin
        if (rst)
            rr_last <= 1'b1;
        else if (state == IDLE && (grant_i || grant_d))
            rr_last <= grant_d;
    end
`else
    localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);
    logic [3:0] starve_cnt;

    always_comb begin
        grant_i = i_pmem_read && (!d_req || starve_cnt == LIMIT);
        grant_d = d_req && !grant_i;
    end

    always_ff @(posedge clk) begin
        if (rst)
            starve_cnt <= '0;
        else if (state == IDLE && grant_i)
            starve_cnt <= '0;
        else if (state == IDLE && grant_d && i_pmem_read && starve_cnt != LIMIT)
            starve_cnt <= starve_cnt + 4'd1;
    end
`endif

    always_ff @(posedge clk) begin
        if (rst)
            state <= IDLE;
        else
            state <= state_next;
    end

    // Holding registers decouple the L2 request from live L1 inputs
    always_ff @(posedge clk) begin
        if (rst) begin
            hold_addr  <= '0;
            hold_write <= 1'b0;
            hold_wdata <= '0;
            i_rdata_q  <= '0;
            d_rdata_q  <= '0;
        end else begin
            if (state == IDLE && grant_i) begin
                hold_addr  <= i_pmem_address;
                hold_write <= 1'b0;
            end else if (state == IDLE && grant_d) begin
                hold_addr  <= d_pmem_address;
                hold_write <= d_pmem_write;
                if (d_pmem_write)
                    hold_wdata <= d_pmem_wdata;
            end
            if (state == SERVE_I && a_pmem_resp)
                i_rdata_q <= a_pmem_rdata;
            if (state == SERVE_D && a_pmem_resp)
                d_rdata_q <= a_pmem_rdata;
        end
    end

    always_comb begin
        state_next     = state;
        a_pmem_read    = 1'b0;
        a_pmem_write   = 1'b0;
        a_pmem_address = '0;
        a_pmem_wdata   = '0;
        i_pmem_resp    = 1'b0;
        d_pmem_resp    = 1'b0;
        case (state)
            IDLE: begin
                if (grant_i)
                    state_next = SERVE_I;
                else if (grant_d)
                    state_next = SERVE_D;
            end
            SERVE_I: begin
                a_pmem_read    = 1'b1;
                a_pmem_address = hold_addr;
                if (a_pmem_resp)
                    state_next = RESP_I;
            end
            SERVE_D: begin
                a_pmem_read    = !hold_write;
                a_pmem_write   = hold_write;
                a_pmem_address = hold_addr;
                if (hold_write)
                    a_pmem_wdata = hold_wdata;
                if (a_pmem_resp)
                    state_next = RESP_D;
            end
            RESP_I: begin
                i_pmem_resp = 1'b1;
                state_next  = IDLE;
            end
            RESP_D: begin
                d_pmem_resp = 1'b1;
                state_next  = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    assign i_pmem_rdata = i_rdata_q;
    assign d_pmem_rdata = d_rdata_q;
    assign busy         = (state != IDLE);

endmodule

// File: tb/tb_l2_port_scheduler.sv
// tb/tb_l2_port_scheduler.sv - randomized self-checking bench for l2_port_scheduler.
module tb_l2_port_scheduler;
    localparam int LW = 256;
    localparam int SL = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          i_pmem_read;
    logic [31:0]   i_pmem_address;
    logic [LW-1:0] i_pmem_rdata;
    logic          i_pmem_resp;
    logic          d_pmem_read;
    logic          d_pmem_write;
    logic [31:0]   d_pmem_address;
    logic [LW-1:0] d_pmem_wdata;
    logic [LW-1:0] d_pmem_rdata;
    logic          d_pmem_resp;
    logic          a_pmem_read;
    logic          a_pmem_write;
    logic [31:0]   a_pmem_address;
    logic [LW-1:0] a_pmem_wdata;
    logic [LW-1:0] a_pmem_rdata;
    logic          a_pmem_resp;
    logic          busy;

    l2_port_scheduler #(.STARVE_LIMIT(SL), .LINE_W(LW)) dut (
        .clk(clk), .rst(rst),
        .i_pmem_read(i_pmem_read), .i_pmem_address(i_pmem_address),
        .i_pmem_rdata(i_pmem_rdata), .i_pmem_resp(i_pmem_resp),
        .d_pmem_read(d_pmem_read), .d_pmem_write(d_pmem_write),
        .d_pmem_address(d_pmem_address), .d_pmem_wdata(d_pmem_wdata),
        .d_pmem_rdata(d_pmem_rdata), .d_pmem_resp(d_pmem_resp),
        .a_pmem_read(a_pmem_read), .a_pmem_write(a_pmem_write),
        .a_pmem_address(a_pmem_address), .a_pmem_wdata(a_pmem_wdata),
        .a_pmem_rdata(a_pmem_rdata), .a_pmem_resp(a_pmem_resp),
        .busy(busy)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // reference model state
    int            m_starve;
    bit            m_rr_last_d;
    logic [LW-1:0] m_irdata, m_drdata;
    bit            i_pend, d_pend;
    int            p_i, p_d;
    int            i_grants, d_grants;

    task automatic chk(input string tag, input logic [LW-1:0] obs, input logic [LW-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [LW-1:0] rnd_line();
        logic [LW-1:0] v;
        for (int k = 0; k < LW / 32; k++) v[k*32 +: 32] = $urandom;
        return v;
    endfunction

    function automatic logic [31:0] rnd_addr();
        return $urandom & 32'hFFFF_FFE0;
    endfunction

    task automatic model_reset();
        m_starve    = 0;
        m_rr_last_d = 1'b1;
        m_irdata    = '0;
        m_drdata    = '0;
    endtask

    task automatic new_requests();
        if (!i_pend && $urandom_range(1, 100) <= p_i) begin
            i_pend         = 1'b1;
            i_pmem_read    = 1'b1;
            i_pmem_address = rnd_addr();
        end
        if (!d_pend && $urandom_range(1, 100) <= p_d) begin
            int op;
            op             = $urandom_range(0, 2);
            d_pend         = 1'b1;
            d_pmem_read    = (op != 1);
            d_pmem_write   = (op != 0);
            d_pmem_address = rnd_addr();
            d_pmem_wdata   = rnd_line();
        end
    endtask

    // Entered at the negedge of an IDLE cycle with requests already driven; returns at the next IDLE negedge.
    task automatic run_txn(input int lat_in);
        bit            ir, dr, win_i, exp_wr;
        logic [31:0]   exp_addr;
        logic [LW-1:0] exp_wdata, line;
        int            lat;
        chk("idle_busy", busy, 0);
        chk("idle_a_req", {a_pmem_read, a_pmem_write}, 0);
        chk("idle_resps", {i_pmem_resp, d_pmem_resp}, 0);
        ir = i_pmem_read;
        dr = d_pmem_read | d_pmem_write;
`ifdef ARB_ROUND_ROBIN_EN
        win_i       = (ir && dr) ? m_rr_last_d : ir;
        m_rr_last_d = !win_i;
`else
        win_i = ir && (!dr || m_starve == SL);
        if (win_i) m_starve = 0;
        else if (ir) m_starve = (m_starve + 1 > SL) ? SL : m_starve + 1;
`endif
        if (win_i) i_grants++; else d_grants++;
        exp_wr    = !win_i && d_pmem_write;
        exp_addr  = win_i ? i_pmem_address : d_pmem_address;
        exp_wdata = exp_wr ? d_pmem_wdata : '0;
        lat       = (lat_in == 0) ? $urandom_range(1, 5) : lat_in;
        line      = rnd_line();
        @(posedge clk);
        for (int c = 1; c <= lat; c++) begin
            @(negedge clk);
            chk("serve_read", a_pmem_read, !exp_wr);
            chk("serve_write", a_pmem_write, exp_wr);
            chk("serve_addr", a_pmem_address, exp_addr);
            chk("serve_wdata", a_pmem_wdata, exp_wdata);
            chk("serve_busy", busy, 1);
            chk("serve_resps", {i_pmem_resp, d_pmem_resp}, 0);
            // live inputs wander; the L2 side must keep the latched values
            if (win_i) begin
                i_pmem_address = rnd_addr();
                if ($urandom_range(0, 3) == 0) begin i_pmem_read = 1'b0; i_pend = 1'b0; end
            end else begin
                d_pmem_address = rnd_addr();
                d_pmem_wdata   = rnd_line();
                if ($urandom_range(0, 3) == 0) begin
                    d_pmem_read = 1'b0; d_pmem_write = 1'b0; d_pend = 1'b0;
                end
            end
            if (c == lat) begin
                a_pmem_resp  = 1'b1;
                a_pmem_rdata = line;
            end
            @(posedge clk);
        end
        @(negedge clk);
        a_pmem_resp  = 1'b0;
        a_pmem_rdata = rnd_line();
        if (win_i) m_irdata = line; else m_drdata = line;
        chk("resp_i", i_pmem_resp, win_i);
        chk("resp_d", d_pmem_resp, !win_i);
        chk("resp_irdata", i_pmem_rdata, m_irdata);
        chk("resp_drdata", d_pmem_rdata, m_drdata);
        chk("resp_a_req", {a_pmem_read, a_pmem_write}, 0);
        chk("resp_busy", busy, 1);
        if (win_i) begin
            i_pmem_read = 1'b0; i_pend = 1'b0;
        end else begin
            d_pmem_read = 1'b0; d_pmem_write = 1'b0; d_pend = 1'b0;
        end
        new_requests();
        @(posedge clk);
        @(negedge clk);
        chk("after_irdata", i_pmem_rdata, m_irdata);
        chk("after_drdata", d_pmem_rdata, m_drdata);
    endtask

    initial begin
        rst = 1'b1;
        i_pmem_read = 1'b0; i_pmem_address = '0;
        d_pmem_read = 1'b0; d_pmem_write = 1'b0; d_pmem_address = '0; d_pmem_wdata = '0;
        a_pmem_rdata = '0; a_pmem_resp = 1'b0;
        i_pend = 1'b0; d_pend = 1'b0; p_i = 50; p_d = 50;
        i_grants = 0; d_grants = 0;
        model_reset();
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_busy", busy, 0);
        chk("rst_a_req", {a_pmem_read, a_pmem_write}, 0);
        chk("rst_a_addr", a_pmem_address, 0);
        chk("rst_a_wdata", a_pmem_wdata, 0);
        chk("rst_resps", {i_pmem_resp, d_pmem_resp}, 0);
        chk("rst_irdata", i_pmem_rdata, 0);
        chk("rst_drdata", d_pmem_rdata, 0);
        rst = 1'b0;

        // I-only read, address 0x40, three-cycle L2 latency
        i_pmem_read = 1'b1; i_pmem_address = 32'h0000_0040; i_pend = 1'b1;
        run_txn(3);

        // D write at 0x1000; wdata is scrambled during SERVE by run_txn
        d_pmem_write = 1'b1; d_pmem_address = 32'h0000_1000; d_pmem_wdata = rnd_line(); d_pend = 1'b1;
        run_txn(2);

        // simultaneous I and D reads
        i_pmem_read = 1'b1; i_pmem_address = rnd_addr(); i_pend = 1'b1;
        d_pmem_read = 1'b1; d_pmem_address = rnd_addr(); d_pend = 1'b1;
        run_txn(0);
        run_txn(0);

        // random traffic, then saturated contention on both sides
        for (int n = 0; n < 240; n++) begin
            if (n == 120) begin p_i = 100; p_d = 100; end
            if (n == 200) begin p_i = 30; p_d = 80; end
            new_requests();
            if (!i_pend && !d_pend) begin
                chk("noreq_busy", busy, 0);
                @(posedge clk);
                @(negedge clk);
                chk("noreq_stay", busy, 0);
                i_pmem_read = 1'b1; i_pmem_address = rnd_addr(); i_pend = 1'b1;
            end
            run_txn(0);
        end

        // reset while SERVE_D is waiting on L2
        i_pmem_read = 1'b0; i_pend = 1'b0;
        d_pmem_read = 1'b0; d_pmem_write = 1'b1; d_pmem_address = 32'h0000_2000;
        d_pmem_wdata = rnd_line(); d_pend = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("rstmid_pre_write", a_pmem_write, 1);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("rstmid_busy", busy, 0);
        chk("rstmid_a_req", {a_pmem_read, a_pmem_write}, 0);
        chk("rstmid_a_addr", a_pmem_address, 0);
        chk("rstmid_resps", {i_pmem_resp, d_pmem_resp}, 0);
        chk("rstmid_drdata", d_pmem_rdata, 0);
        rst = 1'b0;
        d_pmem_write = 1'b0; d_pend = 1'b0;
        model_reset();
        @(posedge clk);
        @(negedge clk);
        chk("rstmid_no_resp", {i_pmem_resp, d_pmem_resp, busy}, 0);
        i_pmem_read = 1'b1; i_pmem_address = 32'h0000_0080; i_pend = 1'b1;
        run_txn(2);

        chk("grants_seen_i", i_grants > 10, 1);
        chk("grants_seen_d", d_grants > 10, 1);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2000000;
        errors++;
        $display("FAIL timeout observed=running expected=finished");
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $fatal(1, "timeout");
    end
endmodule
